// File: rtl/register_bank_sb.sv
// Register bank: 1 sync write port, 2 async read ports, optional bypass/zero reg, busy scoreboard.
// Writes land 1 cycle later (bypassed same cycle when enabled); no backpressure, busy1/busy2 let issue stall.
module register_bank_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rsv_en,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic                  busy1,
  output logic                  busy2,
  output logic [ADDR_WIDTH:0]   busy_count
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_nxt;
  logic [ADDR_WIDTH:0]   busy_count_nxt;
  logic                  wr_ok;
  logic                  rsv_ok;
  logic                  set_new;
  logic                  clr_old;

  assign wr_ok  = we     && !((ZERO_REG != 0) && (waddr == '0));
  assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

  // Reservation is applied after the write clear so the younger producer wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)  busy_nxt[waddr]    = 1'b0;
    if (rsv_ok) busy_nxt[rsv_addr] = 1'b1;
  end

  assign set_new = rsv_ok && !busy[rsv_addr];
  assign clr_old = wr_ok && busy[waddr] && !(rsv_ok && (rsv_addr == waddr));
  assign busy_count_nxt = busy_count + {{ADDR_WIDTH{1'b0}}, set_new}
                                     - {{ADDR_WIDTH{1'b0}}, clr_old};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (wr_ok) mem[waddr] <= wdata;
      busy       <= busy_nxt;
      busy_count <= busy_count_nxt;
    end
  end

  always_comb begin
    rdata1 = mem[raddr1];
    busy1  = busy[raddr1];
    rdata2 = mem[raddr2];
    busy2  = busy[raddr2];
    if ((BYPASS != 0) && wr_ok && (waddr == raddr1)) begin
      rdata1 = wdata;
      busy1  = 1'b0;
    end
    if ((BYPASS != 0) && wr_ok && (waddr == raddr2)) begin
      rdata2 = wdata;
      busy2  = 1'b0;
    end
    // The zero register is masked at the read port as well as in storage.
    if ((ZERO_REG != 0) && (raddr1 == '0)) begin
      rdata1 = '0;
      busy1  = 1'b0;
    end
    if ((ZERO_REG != 0) && (raddr2 == '0)) begin
      rdata2 = '0;
      busy2  = 1'b0;
    end
  end

endmodule

// File: tb/tb_register_bank_sb.sv
// Bench for register_bank_sb: two instances (bypass on/off) against an array-based reference model.
// Directed test-plan scenarios with literal expectations, then randomized traffic with occasional reset.
module tb_register_bank_sb;

  logic        clk = 1'b0;
  logic        reset, we, rsv_en;
  logic [3:0]  waddr, rsv_addr, raddr1, raddr2;
  logic [31:0] wdata;

  logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;
  logic        b_bz1, b_bz2, n_bz1, n_bz2;
  logic [4:0]  b_cnt, n_cnt;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  logic [31:0] m_mem [16];
  logic [15:0] m_busy;

  always #5 clk = ~clk;

  register_bank_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(b_rd1), .rdata2(b_rd2), .busy1(b_bz1), .busy2(b_bz2), .busy_count(b_cnt));

  register_bank_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(n_rd1), .rdata2(n_rd2), .busy1(n_bz1), .busy2(n_bz2), .busy_count(n_cnt));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: the bank as plain arrays; write applied before reservation.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
      m_busy = 16'h0;
    end else begin
      if (we && waddr != 4'd0) begin
        m_mem[waddr]  = wdata;
        m_busy[waddr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 4'd0) m_busy[rsv_addr] = 1'b1;
    end
  end

  function automatic logic [32:0] model_read(input logic [3:0] a, input bit byp);
    if (a == 4'd0) return 33'h0;
    if (byp && we && waddr == a) return {1'b0, wdata};
    return {m_busy[a], m_mem[a]};
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      logic [32:0] e;
      e = model_read(raddr1, 1'b1);
      chk("byp_rdata1", b_rd1, e[31:0]);  chk("byp_busy1", 32'(b_bz1), 32'(e[32]));
      e = model_read(raddr2, 1'b1);
      chk("byp_rdata2", b_rd2, e[31:0]);  chk("byp_busy2", 32'(b_bz2), 32'(e[32]));
      e = model_read(raddr1, 1'b0);
      chk("nb_rdata1", n_rd1, e[31:0]);   chk("nb_busy1", 32'(n_bz1), 32'(e[32]));
      e = model_read(raddr2, 1'b0);
      chk("nb_rdata2", n_rd2, e[31:0]);   chk("nb_busy2", 32'(n_bz2), 32'(e[32]));
      chk("byp_busy_count", 32'(b_cnt), 32'($countones(m_busy)));
      chk("nb_busy_count", 32'(n_cnt), 32'($countones(m_busy)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; we = 1'b0; rsv_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; rsv_en = 1'b0;
    waddr = 4'd0; rsv_addr = 4'd0; raddr1 = 4'd0; raddr2 = 4'd0; wdata = 32'h0;
    step();
    check_en = 1'b1;
    step();
    idle();

    // Reset state over all addresses
    for (int a = 0; a < 16; a++) begin
      raddr1 = 4'(a); raddr2 = 4'(a);
      #3;
      chk("rst_rdata1", b_rd1, 32'h0); chk("rst_rdata2", n_rd2, 32'h0);
      chk("rst_busy", 32'({b_bz1, b_bz2, n_bz1, n_bz2}), 32'h0);
      chk("rst_count", 32'(b_cnt), 32'h0);
      step();
    end

    // Write/read back and zero register
    we = 1'b1; waddr = 4'd5; wdata = 32'hDEADBEEF;
    step();
    we = 1'b0; raddr1 = 4'd5; raddr2 = 4'd5;
    #3;
    chk("wr_r5_p1", b_rd1, 32'hDEADBEEF); chk("wr_r5_p2", b_rd2, 32'hDEADBEEF);
    chk("wr_r5_nb", n_rd2, 32'hDEADBEEF);
    we = 1'b1; waddr = 4'd0; wdata = 32'h12345678; raddr1 = 4'd0;
    step();
    #3;
    chk("r0_during", b_rd1, 32'h0);
    we = 1'b0;
    step();
    #3;
    chk("r0_after", b_rd1, 32'h0); chk("r0_after_nb", n_rd1, 32'h0);

    // Bypass
    we = 1'b1; waddr = 4'd7; wdata = 32'h11111111;
    step();
    wdata = 32'hA5A5A5A5; raddr1 = 4'd7;
    #3;
    chk("byp_same_cycle", b_rd1, 32'hA5A5A5A5); chk("byp_busy0", 32'(b_bz1), 32'h0);
    chk("nb_old_value", n_rd1, 32'h11111111);
    step();
    we = 1'b0;
    #3;
    chk("nb_next_cycle", n_rd1, 32'hA5A5A5A5);

    // Scoreboard
    rsv_en = 1'b1; rsv_addr = 4'd3;
    step();
    rsv_addr = 4'd9;
    step();
    rsv_en = 1'b0; raddr1 = 4'd3; raddr2 = 4'd9;
    #3;
    chk("sb_count2", 32'(b_cnt), 32'd2);
    chk("sb_busy3", 32'(b_bz1), 32'd1); chk("sb_busy9", 32'(n_bz2), 32'd1);
    we = 1'b1; waddr = 4'd3; wdata = 32'h33333333;
    step();
    we = 1'b0;
    #3;
    chk("sb_count1", 32'(b_cnt), 32'd1); chk("sb_busy3_clr", 32'(b_bz1), 32'd0);
    rsv_en = 1'b1; rsv_addr = 4'd9;
    step();
    rsv_en = 1'b0;
    #3;
    chk("sb_rsv_again", 32'(n_cnt), 32'd1);

    // Simultaneous reserve + write, r4 busy beforehand
    rsv_en = 1'b1; rsv_addr = 4'd4;
    step();
    we = 1'b1; waddr = 4'd4; wdata = 32'hCAFEF00D;
    step();
    idle(); raddr1 = 4'd4;
    #3;
    chk("rw_busy_data", b_rd1, 32'hCAFEF00D); chk("rw_busy_b", 32'(b_bz1), 32'd1);
    chk("rw_busy_cnt", 32'(b_cnt), 32'd2);
    // r4 idle beforehand
    we = 1'b1; wdata = 32'h44444444;
    step();
    #3;
    chk("rw_idle_pre_cnt", 32'(b_cnt), 32'd1);
    rsv_en = 1'b1; rsv_addr = 4'd4; wdata = 32'h0BADC0DE;
    step();
    idle();
    #3;
    chk("rw_idle_data", n_rd1, 32'h0BADC0DE); chk("rw_idle_b", 32'(n_bz1), 32'd1);
    chk("rw_idle_cnt", 32'(b_cnt), 32'd2);

    // Reset mid-operation with 5 busy and a write pending
    rsv_en = 1'b1;
    for (int a = 1; a <= 3; a++) begin
      rsv_addr = 4'(a);
      step();
    end
    rsv_en = 1'b0;
    #3;
    chk("pre_rst_cnt", 32'(b_cnt), 32'd5);
    reset = 1'b1; we = 1'b1; waddr = 4'd5; wdata = 32'hFFFFFFFF; rsv_en = 1'b1; rsv_addr = 4'd7;
    step();
    idle(); raddr1 = 4'd5; raddr2 = 4'd4;
    #3;
    chk("mid_rst_data", b_rd1, 32'h0); chk("mid_rst_data_nb", n_rd1, 32'h0);
    chk("mid_rst_cnt", 32'(b_cnt), 32'd0); chk("mid_rst_busy", 32'(b_bz2), 32'd0);
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 149) == 0);
      we       = 1'($urandom_range(0, 1));
      rsv_en   = 1'($urandom_range(0, 1));
      waddr    = 4'($urandom_range(0, 15));
      rsv_addr = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
      wdata    = $urandom;
      raddr1   = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
      raddr2   = ($urandom_range(0, 3) == 0) ? raddr1 : 4'($urandom_range(0, 15));
      step();
    end

    idle();
    step();
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_bank_sb.md
# register_bank_sb

Parametrised, clocked successor to the 16×32 combinational register bank. It provides one synchronous write port and two asynchronous read ports, with optional write-to-read bypass and an optional hardwired zero register. It also keeps a per-register scoreboard of "busy" bits so the issue logic can stall on pending results. It sits between the decode/issue stage (reads, reservations) and the writeback stage (writes).

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 4, address width; number of registers NUM_REGS = 2**ADDR_WIDTH.
- ZERO_REG, 1. When 1, register 0 always reads 0; writes and reservations to it are ignored.
- BYPASS, 1. When 1, a same-cycle write is forwarded to the read ports.

Ports:
- clk, input, 1, the single clock; all state updates on its rising edge.
- reset, input, 1, synchronous, active-high reset.
- we, input, 1, write enable (writeback).
- waddr, input, ADDR_WIDTH, write address.
- wdata, input, DATA_WIDTH, write data.
- rsv_en, input, 1, reserve (mark busy) register rsv_addr.
- rsv_addr, input, ADDR_WIDTH, reservation address.
- raddr1, raddr2, input, ADDR_WIDTH, read addresses.
- rdata1, rdata2, output, DATA_WIDTH, read data (combinational).
- busy1, busy2, output, 1, the read register has a pending write (combinational).
- busy_count, output, ADDR_WIDTH+1, number of currently busy registers (registered).

## Operation
- Storage: NUM_REGS × DATA_WIDTH flops, plus a NUM_REGS-bit busy vector.
- Write: on the clock edge with we=1, mem[waddr] <= wdata and busy[waddr] <= 0, unless a reservation to the same address occurs in the same cycle.
- Reserve: on the clock edge with rsv_en=1, busy[rsv_addr] <= 1.
- Reserve and write to the same address in the same cycle: the reservation wins. Data is written and busy stays/becomes 1, because the new producer is younger.
- Reserve to an already busy register: busy stays 1 and busy_count is unchanged.
- Write to a non-busy register: data is written and busy_count is unchanged.
- ZERO_REG=1: writes, reservations and busy state for address 0 are suppressed. rdata for address 0 is 0 and busy is 0.
- Read, BYPASS=1: if we=1 and waddr==raddrN (and not suppressed zero register), rdataN=wdata and busyN=0. Otherwise rdataN=mem[raddrN] and busyN=busy[raddrN].
- Read, BYPASS=0: rdataN=mem[raddrN] and busyN=busy[raddrN], always.
- busy_count next value = current + (reservation sets a new bit) − (write clears a set bit). It is held equal to popcount(busy) at all times and ranges 0..NUM_REGS (NUM_REGS-1 when ZERO_REG=1). There is no wrap-around.

## Timing
- Reset: all registers 0, busy vector 0, busy_count 0. rdata1/rdata2 read 0 and busy1/busy2 read 0 from the cycle after reset is sampled.
- Reset asserted in the same cycle as we or rsv_en: reset wins, and nothing is written or reserved.
- Write latency: 1 cycle to storage. With BYPASS=1 the read ports see the new data in the same cycle; with BYPASS=0 they see it in the next cycle.
- Reservation latency: busyN reflects the reservation in the next cycle. There is no same-cycle bypass of rsv_en onto busy.
- Both read ports may address the same register and must return identical values.
- busy_count updates on the same edge as the busy vector.

## Test plan
- Reset then read: assert reset for 2 cycles, read all 16 addresses on both ports -> rdata=0x00000000, busy=0, busy_count=0.
- Write and read back: write 0xDEADBEEF to r5, then r5 on both ports next cycle -> 0xDEADBEEF on both. Write 0x12345678 to r0 with ZERO_REG=1 -> r0 reads 0.
- Bypass: with BYPASS=1 and we=1, waddr=7, wdata=0xA5A5A5A5, raddr1=7 in the same cycle -> rdata1=0xA5A5A5A5, busy1=0. Rerun with BYPASS=0 -> rdata1 shows the old r7 value that cycle and 0xA5A5A5A5 the next.
- Scoreboard: reserve r3 and r9 -> busy_count=2 and busy asserted for both. Write r3 -> busy_count=1 and busy for r3 clear. Reserve r9 again -> busy_count stays 1.
- Simultaneous reserve and write to r4, with r4 busy beforehand: data updates, busy stays 1, busy_count unchanged. With r4 idle beforehand: busy becomes 1 and busy_count increments by 1.
- Reset mid-operation: with 5 registers busy and a write pending, assert reset -> next cycle all data 0, busy_count 0, and the pending write is discarded.
